// File: rtl/multdiv_engine.sv
// multdiv_engine: iterative signed multiply / divide responder.
// One start pulse latches operand magnitudes, WIDTH shift-add or restoring
// iterations follow, then a one-cycle DONE state presents the result,
// exception flag and ready pulse.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for a start pulse; last result/exception held
//   RUN   | one iteration per edge until the counter reaches WIDTH
//   DONE  | result valid, data_resultRDY high for this single cycle
module multdiv_engine #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             op_div_q, op_div_d;
  logic             neg_q, neg_d;
  // hi: product high half / partial remainder
  // lo: multiplier being consumed / quotient being built
  // b:  multiplicand magnitude / divisor magnitude
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;
  logic             busy_q, busy_d;

  logic             start;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_rem;
  logic             div_ge;
  logic [WIDTH-1:0] div_sub;
  logic [2*WIDTH-1:0] prod_mag, prod_signed;
  logic [WIDTH-1:0] quot_signed;

  // Datapath helpers: operand magnitudes, one iteration step, final sign fix-up
  always_comb begin
    start       = ctrl_MULT | ctrl_DIV;
    a_mag       = data_operandA[WIDTH-1] ? (~data_operandA + WIDTH'(1)) : data_operandA;
    b_mag       = data_operandB[WIDTH-1] ? (~data_operandB + WIDTH'(1)) : data_operandB;
    mul_sum     = {1'b0, hi_q} + {1'b0, (lo_q[0] ? b_q : '0)};
    div_rem     = {hi_q, lo_q[WIDTH-1]};
    div_ge      = div_rem >= {1'b0, b_q};
    div_sub     = WIDTH'(div_rem - {1'b0, b_q});
    prod_mag    = {hi_q, lo_q};
    prod_signed = neg_q ? (~prod_mag + (2*WIDTH)'(1)) : prod_mag;
    quot_signed = neg_q ? (~lo_q + WIDTH'(1)) : lo_q;
  end

  // Next-state and next-output logic; a start pulse overrides any state
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_div_d = op_div_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    b_d      = b_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
    busy_d   = busy_q;

    if (start) begin
      state_d  = RUN;
      cnt_d    = '0;
      op_div_d = ~ctrl_MULT;
      neg_d    = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      hi_d     = '0;
      lo_d     = ctrl_MULT ? b_mag : a_mag;
      b_d      = ctrl_MULT ? a_mag : b_mag;
      busy_d   = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          busy_d = 1'b0;
        end
        RUN: begin
          if (cnt_q == CW'(WIDTH)) begin
            state_d = DONE;
            busy_d  = 1'b0;
            rdy_d   = 1'b1;
            if (!op_div_q) begin
              result_d = prod_signed[WIDTH-1:0];
              exc_d    = prod_signed[2*WIDTH-1:WIDTH] != {WIDTH{prod_signed[WIDTH-1]}};
            end else if (b_q == '0) begin
              result_d = '0;
              exc_d    = 1'b1;
            end else begin
              result_d = quot_signed;
              // only |most-negative / -1| yields a positive quotient with the MSB set
              exc_d    = ~neg_q & lo_q[WIDTH-1];
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
            if (!op_div_q) begin
              hi_d = mul_sum[WIDTH:1];
              lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
            end else begin
              hi_d = div_ge ? div_sub : div_rem[WIDTH-1:0];
              lo_d = {lo_q[WIDTH-2:0], div_ge};
            end
          end
        end
        DONE: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_div_q <= 1'b0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_div_q <= op_div_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      b_q      <= b_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_multdiv_engine.sv
// Bench for multdiv_engine: directed cases plus random operations checked
// against a plain-arithmetic reference model.
module tb_multdiv_engine;

  logic        clock;
  logic        reset_n;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;

  multdiv_engine #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: 64-bit signed arithmetic straight from the operation rules
  task automatic model(input logic is_mult, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic e);
    longint sa, sb, p, q;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (is_mult) begin
      p = sa * sb;
      r = p[31:0];
      e = (p != longint'($signed(p[31:0])));
    end else if (sb == 0) begin
      r = 32'h0;
      e = 1'b1;
    end else begin
      q = sa / sb;
      r = q[31:0];
      e = (q > 64'sd2147483647);
    end
  endtask

  // Issue one operation and follow it to completion
  task automatic run_op(input logic m, input logic d, input logic [31:0] a,
                        input logic [31:0] b, input string tag);
    logic [31:0] er;
    logic        ee;
    int          lat;
    int          k;
    bit          busy_ok;
    model(m, a, b, er, ee);
    @(negedge clock);
    ctrl_MULT = m; ctrl_DIV = d; data_operandA = a; data_operandB = b;
    @(negedge clock);
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = $urandom; data_operandB = $urandom;
    lat = -1; k = 0; busy_ok = 1'b1;
    while (lat < 0 && k < 60) begin
      if (data_resultRDY === 1'b1) lat = k;
      else begin
        if (busy !== 1'b1) busy_ok = 1'b0;
        k++;
        @(negedge clock);
      end
    end
    check({tag, " latency"}, 64'(lat), 64'd33);
    check({tag, " busy_run"}, 64'(busy_ok), 64'd1);
    check({tag, " busy_done"}, 64'(busy), 64'd0);
    check({tag, " result"}, 64'(data_result), 64'(er));
    check({tag, " exception"}, 64'(data_exception), 64'(ee));
    @(negedge clock);
    check({tag, " rdy_pulse"}, 64'(data_resultRDY), 64'd0);
    check({tag, " result_hold"}, 64'(data_result), 64'(er));
  endtask

  initial begin
    int          rdy_cnt;
    int          lat;
    logic [31:0] res;
    logic        ra;
    logic [31:0] a, b;

    reset_n = 1'b0; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = 32'h0; data_operandB = 32'h0;
    repeat (3) @(negedge clock);
    check("reset result", 64'(data_result), 64'd0);
    check("reset exception", 64'(data_exception), 64'd0);
    check("reset rdy", 64'(data_resultRDY), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    reset_n = 1'b1;

    // directed multiply / divide cases
    run_op(1'b1, 1'b0, 32'd7, -32'sd6, "mul 7*-6");
    check("mul 7*-6 value", 64'(data_result), 64'hFFFFFFD6);
    run_op(1'b1, 1'b0, 32'h00010000, 32'h00010000, "mul ovf");
    run_op(1'b1, 1'b0, 32'h80000000, 32'd1, "mul min*1");
    run_op(1'b0, 1'b1, -32'sd7, 32'd2, "div -7/2");
    check("div -7/2 value", 64'(data_result), 64'hFFFFFFFD);
    run_op(1'b0, 1'b1, 32'd100, -32'sd10, "div 100/-10");
    run_op(1'b0, 1'b1, 32'd5, 32'd0, "div by zero");
    check("div by zero exc", 64'(data_exception), 64'd1);
    run_op(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, "div min/-1");
    check("div min/-1 value", 64'(data_result), 64'h80000000);

    // restart: DIV then MULT on edge 10, only the MULT completes
    @(negedge clock);
    ctrl_DIV = 1'b1; data_operandA = 32'd100; data_operandB = 32'd3;
    @(negedge clock);
    ctrl_DIV = 1'b0;
    rdy_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      if (data_resultRDY === 1'b1) rdy_cnt++;
      @(negedge clock);
    end
    ctrl_MULT = 1'b1; data_operandA = 32'd3; data_operandB = 32'd4;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    lat = -1; res = 32'hDEADBEEF;
    for (int k = 0; k < 60; k++) begin
      if (data_resultRDY === 1'b1) begin
        rdy_cnt++;
        if (lat < 0) begin lat = k; res = data_result; end
      end
      @(negedge clock);
    end
    check("restart rdy count", 64'(rdy_cnt), 64'd1);
    check("restart latency", 64'(lat), 64'd33);
    check("restart result", 64'(res), 64'd12);

    run_op(1'b1, 1'b1, 32'd6, 32'd3, "mult priority");
    check("mult priority value", 64'(data_result), 64'd18);

    // asynchronous reset mid-run
    @(negedge clock);
    ctrl_DIV = 1'b1; data_operandA = 32'd1000; data_operandB = 32'd7;
    @(negedge clock);
    ctrl_DIV = 1'b0;
    repeat (14) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("async rst result", 64'(data_result), 64'd0);
    check("async rst exception", 64'(data_exception), 64'd0);
    check("async rst rdy", 64'(data_resultRDY), 64'd0);
    check("async rst busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    rdy_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (data_resultRDY === 1'b1) rdy_cnt++;
      @(negedge clock);
    end
    check("no rdy after reset", 64'(rdy_cnt), 64'd0);

    run_op(1'b0, 1'b1, 32'd9, 32'd3, "div 9/3");
    for (int k = 0; k < 5; k++) begin
      data_operandA = $urandom; data_operandB = $urandom;
      @(negedge clock);
      check("idle hold result", 64'(data_result), 64'd3);
      check("idle no rdy", 64'(data_resultRDY), 64'd0);
    end

    // random operations against the model
    for (int n = 0; n < 40; n++) begin
      ra = $urandom_range(0, 1);
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 3))
        0: begin a = $urandom_range(0, 40); b = $urandom_range(0, 9); end
        1: begin a = -$urandom_range(0, 5000); b = $urandom_range(1, 300); end
        2: b = $urandom_range(0, 1) ? 32'h0 : -$urandom_range(1, 20);
        default: ;
      endcase
      run_op(ra, ~ra, a, b, ra ? "rand mul" : "rand div");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
